// File: rtl/xibus_pkg.sv
// xibus_pkg: shared types and helpers for the XiBus master.
//   xb_state_e    master FSM states
//   TM_*          {tm1n,tm0n} transfer-mode codes (active low on the bus)
//   xibus_encode  byte strobes -> {illegal, tm1n, tm0n, ad[1:0]}
package xibus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    ERR
  } xb_state_e;

  localparam logic [1:0] TM_READ = 2'b11;
  localparam logic [1:0] TM_BYTE = 2'b00;
  localparam logic [1:0] TM_HALF = 2'b01;
  localparam logic [1:0] TM_WORD = 2'b01;

  localparam logic [4:0] ENC_ILLEGAL = {1'b1, TM_READ, 2'b00};

  function automatic logic [4:0] xibus_encode(input logic [3:0] wr);
    logic [4:0] enc;
    case (wr)
      4'b0000: enc = {1'b0, TM_READ, 2'b00};
      4'b0001: enc = {1'b0, TM_BYTE, 2'b00};
      4'b0010: enc = {1'b0, TM_BYTE, 2'b10};
      4'b0100: enc = {1'b0, TM_BYTE, 2'b01};
      4'b1000: enc = {1'b0, TM_BYTE, 2'b11};
      4'b0011: enc = {1'b0, TM_HALF, 2'b01};
      4'b1100: enc = {1'b0, TM_HALF, 2'b11};
      4'b1111: enc = {1'b0, TM_WORD, 2'b00};
      default: enc = ENC_ILLEGAL;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/xibus_master_if.sv
// xibus_master_if: XiBus pad-side signals.
//   xb_ad_o/xb_ad_oe/xb_ad_i   multiplexed address/data, output enable, input
//   xb_asn_o/xb_dsn_o          address/data strobes (active low)
//   xb_tm1n_o/xb_tm0n_o        transfer mode (active low)
//   xb_ackn_i                  target acknowledge (active low)
// Modports: master (the bus master), slave (target / pad ring view).
interface xibus_master_if;
  logic [31:0] xb_ad_o;
  logic        xb_ad_oe;
  logic [31:0] xb_ad_i;
  logic        xb_asn_o;
  logic        xb_dsn_o;
  logic        xb_tm1n_o;
  logic        xb_tm0n_o;
  logic        xb_ackn_i;

  modport master (
    output xb_ad_o, xb_ad_oe, xb_asn_o, xb_dsn_o, xb_tm1n_o, xb_tm0n_o,
    input  xb_ad_i, xb_ackn_i
  );

  modport slave (
    input  xb_ad_o, xb_ad_oe, xb_asn_o, xb_dsn_o, xb_tm1n_o, xb_tm0n_o,
    output xb_ad_i, xb_ackn_i
  );
endinterface

// File: rtl/xibus_ack_sync.sv
// xibus_ack_sync: two-flop synchroniser for the active-low acknowledge.
//   clk, rst_n  clock, async active-low reset (flops reset to 1 = no ack)
//   ackn_i      raw acknowledge from the pad
//   ackn_o      synchronised acknowledge
module xibus_ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ackn_i,
  output logic ackn_o
);
  logic ff1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1    <= 1'b1;
      ackn_o <= 1'b1;
    end else begin
      ff1    <= ackn_i;
      ackn_o <= ff1;
    end
  end
endmodule

// File: rtl/xibus_master.sv
// xibus_master: sequential XiBus master, one CPU request at a time.
//   clk, rst_n            bus clock, async active-low reset
//   cpu_req/cpu_gnt       request / accepted (gnt high only in IDLE)
//   cpu_write             byte strobes, 0000 = word read
//   cpu_addr, cpu_wdata   byte address ([1:0] ignored), write data
//   cpu_rdata             read data, valid with cpu_done
//   cpu_done, cpu_err     1-cycle completion pulse, error qualifier
//   xb                    XiBus pad signals (xibus_master_if.master)
// Optional feature: define XIBUS_TIMEOUT_EN to enable the data-phase watchdog.
//
// state | meaning
// IDLE  | grant offered, waiting for cpu_req
// ADDR  | address phase, asn low for ADDR_HOLD cycles
// DATA  | data phase, dsn low until acknowledge (or watchdog)
// DONE  | completion pulse, bus turnaround
// ERR   | illegal strobe pattern reported, no bus activity
module xibus_master
  import xibus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ADDR_HOLD = 1,
  parameter int ACK_SYNC  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_gnt,
  input  logic [3:0]        cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  xibus_master_if.master    xb
);
  localparam int ADW = (ADDR_W > 32) ? ADDR_W : 32;

  xb_state_e   state, state_nxt;
  logic        ready_q;
  logic [3:0]  hold_cnt;
  logic [31:0] addr_ad_q;
  logic [1:0]  tm_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ackn_s;
  logic [4:0]  enc;
  logic [ADW-1:0] addr_ext;
  logic        accept;
  logic        unused_addr;

  assign enc         = xibus_encode(cpu_write);
  assign addr_ext    = ADW'(cpu_addr);
  assign unused_addr = ^addr_ext;
  assign accept      = (state == IDLE) && cpu_req && ready_q;
  assign cpu_rdata   = rdata_q;

  generate
    if (ACK_SYNC != 0) begin : g_sync
      xibus_ack_sync u_ack_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ackn_i (xb.xb_ackn_i),
        .ackn_o (ackn_s)
      );
    end else begin : g_nosync
      assign ackn_s = xb.xb_ackn_i;
    end
  endgenerate

`ifdef XIBUS_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_err_q;

  // Down-counter loaded on DATA entry; terminal count at zero means the
  // last allowed DATA cycle passed without acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (accept) to_err_q <= 1'b0;
      if (state == ADDR && hold_cnt == 4'd0) begin
        to_cnt <= 16'(TIMEOUT - 1);
      end else if (state == DATA && to_cnt != 16'd0) begin
        to_cnt <= to_cnt - 16'd1;
      end
      if (state == DATA && ackn_s && to_cnt == 16'd0) to_err_q <= 1'b1;
    end
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ready_q keeps the grant low for the first cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      hold_cnt  <= '0;
      addr_ad_q <= '0;
      tm_q      <= 2'b11;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        hold_cnt  <= 4'(ADDR_HOLD - 1);
        addr_ad_q <= {addr_ext[31:2], enc[1:0]};
        tm_q      <= enc[3:2];
        wr_q      <= (cpu_write != 4'b0000);
        wdata_q   <= cpu_wdata;
      end else if (state == ADDR && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end
      if (state == DATA && !ackn_s && !wr_q) rdata_q <= xb.xb_ad_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    cpu_gnt      = 1'b0;
    cpu_done     = 1'b0;
    cpu_err      = 1'b0;
    xb.xb_ad_o   = '0;
    xb.xb_ad_oe  = 1'b0;
    xb.xb_asn_o  = 1'b1;
    xb.xb_dsn_o  = 1'b1;
    xb.xb_tm1n_o = 1'b1;
    xb.xb_tm0n_o = 1'b1;
    case (state)
      IDLE: begin
        cpu_gnt = ready_q;
        if (accept) state_nxt = enc[4] ? ERR : ADDR;
      end
      ADDR: begin
        xb.xb_asn_o  = 1'b0;
        xb.xb_ad_oe  = 1'b1;
        xb.xb_ad_o   = addr_ad_q;
        xb.xb_tm1n_o = tm_q[1];
        xb.xb_tm0n_o = tm_q[0];
        if (hold_cnt == 4'd0) state_nxt = DATA;
      end
      DATA: begin
        xb.xb_dsn_o  = 1'b0;
        xb.xb_tm1n_o = tm_q[1];
        xb.xb_tm0n_o = tm_q[0];
        if (wr_q) begin
          xb.xb_ad_oe = 1'b1;
          xb.xb_ad_o  = wdata_q;
        end
        if (!ackn_s) state_nxt = DONE;
`ifdef XIBUS_TIMEOUT_EN
        else if (to_cnt == 16'd0) state_nxt = DONE;
`endif
      end
      DONE: begin
        cpu_done  = 1'b1;
`ifdef XIBUS_TIMEOUT_EN
        cpu_err   = to_err_q;
`endif
        state_nxt = IDLE;
      end
      ERR: begin
        cpu_done  = 1'b1;
        cpu_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_xibus_master.sv
// tb_xibus_master: two instances (ACK_SYNC=0 and ACK_SYNC=1) share CPU stimulus;
// each has its own acknowledge-generating target model and scoreboard pointer.
module tb_xibus_master;
  import xibus_pkg::*;

  localparam int TO_LIM = 16;
  localparam int NOACK  = 1000;
  localparam int NV     = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        g0, d0, e0, g1, d1, e1;
  logic [31:0] r0, r1;

  xibus_master_if bus0 ();
  xibus_master_if bus1 ();

  xibus_master #(.ADDR_W(32), .ADDR_HOLD(1), .ACK_SYNC(0), .TIMEOUT(TO_LIM)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_gnt(g0), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(r0), .cpu_done(d0),
    .cpu_err(e0), .xb(bus0)
  );
  xibus_master #(.ADDR_W(32), .ADDR_HOLD(1), .ACK_SYNC(1), .TIMEOUT(TO_LIM)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_gnt(g1), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(r1), .cpu_done(d1),
    .cpu_err(e1), .xb(bus1)
  );

  logic        gnt[2], done[2], err[2], asn_v[2], dsn_v[2], oe_v[2], ackn_v[2];
  logic [31:0] rdata[2], ad_v[2];
  logic [1:0]  tm_v[2];
  int          cur_delay;
  bit          cur_early;
  logic [31:0] cur_rdin;

  assign gnt[0] = g0;  assign gnt[1] = g1;
  assign done[0] = d0; assign done[1] = d1;
  assign err[0] = e0;  assign err[1] = e1;
  assign rdata[0] = r0; assign rdata[1] = r1;
  assign asn_v[0] = bus0.xb_asn_o; assign asn_v[1] = bus1.xb_asn_o;
  assign dsn_v[0] = bus0.xb_dsn_o; assign dsn_v[1] = bus1.xb_dsn_o;
  assign oe_v[0]  = bus0.xb_ad_oe; assign oe_v[1]  = bus1.xb_ad_oe;
  assign ad_v[0]  = bus0.xb_ad_o;  assign ad_v[1]  = bus1.xb_ad_o;
  assign tm_v[0]  = {bus0.xb_tm1n_o, bus0.xb_tm0n_o};
  assign tm_v[1]  = {bus1.xb_tm1n_o, bus1.xb_tm0n_o};
  assign bus0.xb_ackn_i = ackn_v[0];
  assign bus1.xb_ackn_i = ackn_v[1];
  // read data is only correct while the target acknowledges
  assign bus0.xb_ad_i = ackn_v[0] ? ~cur_rdin : cur_rdin;
  assign bus1.xb_ad_i = ackn_v[1] ? ~cur_rdin : cur_rdin;

  typedef struct {
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          early;
    logic [31:0] rdin;
    logic [31:0] ad_exp;
    logic [1:0]  tm_exp;
    bit          err_exp;
  } vec_t;

  typedef struct {
    bit          illegal;
    bit          err;
    bit          rd;
    logic [31:0] ad_addr;
    logic [1:0]  tm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat0;
    int          lat1;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[64];
  exp_t mon_e;
  int   wr_idx = 0;
  int   rd_idx[2] = '{0, 0};
  int   acc_cyc[2] = '{0, 0};
  int   prev_acc[2] = '{0, 0};
  int   acc_cnt[2] = '{0, 0};
  int   done_cnt[2] = '{0, 0};
  logic done_prev[2] = '{1'b0, 1'b0};
  int   dcnt[2] = '{0, 0};
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, k, act, ex, $time);
  endtask

  always @(posedge clk) cyc++;

  // target model: ack after 'delay' DATA cycles, or from the address phase when early
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        dcnt[k] = 0;
        ackn_v[k] = 1'b1;
      end else if (!dsn_v[k]) begin
        ackn_v[k] = !(dcnt[k] >= cur_delay);
        dcnt[k]++;
      end else begin
        dcnt[k] = 0;
        ackn_v[k] = !(cur_early && !asn_v[k]);
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (cpu_req && gnt[k]) begin
          prev_acc[k] = acc_cyc[k];
          acc_cyc[k] = cyc;
          acc_cnt[k]++;
        end
        if (rd_idx[k] < wr_idx) begin
          mon_e = sb[rd_idx[k]];
          if (mon_e.illegal) begin
            chk("illegal_no_asn", k, 32'(asn_v[k]), 32'd1);
            chk("illegal_no_dsn", k, 32'(dsn_v[k]), 32'd1);
          end else begin
            if (!asn_v[k]) begin
              chk("addr_ad", k, ad_v[k], mon_e.ad_addr);
              chk("addr_tm", k, 32'(tm_v[k]), 32'(mon_e.tm));
              chk("addr_oe", k, 32'(oe_v[k]), 32'd1);
            end
            if (!dsn_v[k]) begin
              chk("data_tm", k, 32'(tm_v[k]), 32'(mon_e.tm));
              if (mon_e.rd) chk("rd_oe", k, 32'(oe_v[k]), 32'd0);
              else begin
                chk("wr_oe", k, 32'(oe_v[k]), 32'd1);
                chk("wr_ad", k, ad_v[k], mon_e.wdata);
              end
            end
          end
          if (done[k]) begin
            chk("done_err", k, 32'(err[k]), 32'(mon_e.err));
            chk("done_rdata", k, rdata[k], mon_e.rdata);
            chk("done_latency", k, 32'(cyc - acc_cyc[k]), 32'((k == 0) ? mon_e.lat0 : mon_e.lat1));
            chk("done_gnt", k, 32'(gnt[k]), 32'd0);
            chk("done_bus_idle", k, {29'd0, oe_v[k], asn_v[k], dsn_v[k]}, 32'd3);
            chk("done_pulse", k, 32'(done_prev[k]), 32'd0);
            rd_idx[k]++;
            done_cnt[k]++;
          end
        end else if (done[k]) begin
          chk("spurious_done", k, 32'd1, 32'd0);
        end
        done_prev[k] = done[k];
      end
    end
  end

  task automatic push(input vec_t v);
    exp_t e;
    e.illegal = v.err_exp;
    e.err     = v.err_exp;
    e.rd      = (v.wr == 4'b0000);
    e.ad_addr = v.ad_exp;
    e.tm      = v.tm_exp;
    e.wdata   = v.wdata;
    if (v.err_exp) begin
      e.lat0 = 1; e.lat1 = 1;
    end else if (v.delay >= NOACK) begin
      e.err = 1'b1; e.lat0 = 2 + TO_LIM; e.lat1 = 2 + TO_LIM;
    end else if (v.early) begin
      e.lat0 = 3; e.lat1 = 4;
    end else begin
      e.lat0 = 3 + v.delay; e.lat1 = 5 + v.delay;
    end
    if (e.rd && !e.err) last_rd = v.rdin;
    e.rdata = last_rd;
    sb[wr_idx] = e;
    wr_idx++;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin @(posedge clk); #1; g++; end while (!(gnt[0] && gnt[1]) && g < 300);
    if (g >= 300) chk("idle_wait_timeout", 0, 32'd1, 32'd0);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((rd_idx[0] < wr_idx || rd_idx[1] < wr_idx) && g < 300) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 300) begin
      chk("done_wait_timeout", 0, 32'd1, 32'd0);
      rd_idx[0] = wr_idx; rd_idx[1] = wr_idx;
    end
  endtask

  task automatic start_vec(input vec_t v);
    wait_idle();
    push(v);
    cur_delay = v.delay; cur_early = v.early; cur_rdin = v.rdin;
    cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_vec(v);
    wait_drain();
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_gnt"}, k, 32'(gnt[k]), 32'd0);
      chk({tag, "_done_err"}, k, {30'd0, done[k], err[k]}, 32'd0);
      chk({tag, "_rdata"}, k, rdata[k], 32'd0);
      chk({tag, "_ad"}, k, ad_v[k], 32'd0);
      chk({tag, "_oe_asn_dsn_tm"}, k, {27'd0, oe_v[k], asn_v[k], dsn_v[k], tm_v[k]}, 32'h0F);
    end
  endtask

  initial begin
    int base1, g;
    vec_t rv;
    //          wr       addr          wdata         dly   early rdin          ad_exp        tm     err
    vt[0]  = '{4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 0,    0, 32'h0,         32'h1000_0004, 2'b01, 0};
    vt[1]  = '{4'b0010, 32'h0000_0020, 32'h0000_AB00, 0,    0, 32'h0,         32'h0000_0022, 2'b00, 0};
    vt[2]  = '{4'b1100, 32'h0000_0020, 32'hCAFE_0000, 0,    0, 32'h0,         32'h0000_0023, 2'b01, 0};
    vt[3]  = '{4'b0000, 32'h0000_0040, 32'h0,         5,    0, 32'h1234_5678, 32'h0000_0040, 2'b11, 0};
    vt[4]  = '{4'b0101, 32'h0000_0050, 32'h1111_1111, 0,    0, 32'h0,         32'h0,         2'b11, 1};
    vt[5]  = '{4'b0001, 32'h0000_0103, 32'h0000_0077, 1,    0, 32'h0,         32'h0000_0100, 2'b00, 0};
    vt[6]  = '{4'b0100, 32'h0000_0008, 32'h0055_0000, 0,    0, 32'h0,         32'h0000_0009, 2'b00, 0};
    vt[7]  = '{4'b1000, 32'h0000_000C, 32'h6600_0000, 2,    0, 32'h0,         32'h0000_000F, 2'b00, 0};
    vt[8]  = '{4'b0011, 32'h0000_0010, 32'h0000_3344, 0,    0, 32'h0,         32'h0000_0011, 2'b01, 0};
    vt[9]  = '{4'b1110, 32'h0000_0060, 32'h2222_2222, 0,    0, 32'h0,         32'h0,         2'b11, 1};
    vt[10] = '{4'b0000, 32'hFFFF_FFFE, 32'h0,         0,    0, 32'hA5A5_5A5A, 32'hFFFF_FFFC, 2'b11, 0};
    vt[11] = '{4'b1111, 32'h0000_0200, 32'h0BAD_F00D, 0,    1, 32'h0,         32'h0000_0200, 2'b01, 0};

    rst_n = 1'b0; cpu_req = 1'b0; cpu_write = '0; cpu_addr = '0; cpu_wdata = '0;
    cur_delay = 0; cur_early = 1'b0; cur_rdin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vt[i]);

`ifdef XIBUS_TIMEOUT_EN
    rv = '{4'b0000, 32'h0000_0300, 32'h0, NOACK, 0, 32'h7777_7777, 32'h0000_0300, 2'b11, 0};
    run_vec(rv);
`endif

    // reset in the middle of a long read: silent abort, bus released at once
    rv = '{4'b0000, 32'h0000_0400, 32'h0, 40, 0, 32'h3C3C_3C3C, 32'h0000_0400, 2'b11, 0};
    start_vec(rv);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_data_dsn", 0, 32'(dsn_v[0]), 32'd0);
    chk("mid_data_dsn", 1, 32'(dsn_v[1]), 32'd0);
    base1 = done_cnt[0] + done_cnt[1];
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    rd_idx[0] = wr_idx; rd_idx[1] = wr_idx; last_rd = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_reset", 0, 32'(done_cnt[0] + done_cnt[1]), 32'(base1));
    run_vec(vt[1]);
    run_vec(vt[3]);

    // cpu_req held: re-accepted only on return to IDLE
    wait_idle();
    rv = '{4'b1111, 32'h0000_0030, 32'h0BAD_CAFE, 0, 0, 32'h0, 32'h0000_0030, 2'b01, 0};
    push(rv); push(rv);
    base1 = acc_cnt[1];
    cur_delay = 0; cur_early = 1'b0;
    cpu_write = rv.wr; cpu_addr = rv.addr; cpu_wdata = rv.wdata;
    cpu_req = 1'b1;
    g = 0;
    while (acc_cnt[1] < base1 + 2 && g < 100) begin @(posedge clk); #1; g++; end
    cpu_req = 1'b0;
    chk("held_req_period", 0, 32'(acc_cyc[0] - prev_acc[0]), 32'd4);
    chk("held_req_period", 1, 32'(acc_cyc[1] - prev_acc[1]), 32'd6);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
